// File: rtl/bus_master_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_port_pkg
//  Description : Shared encodings for the bus master port: FSM states,
//                active-low/active-high enable levels and rw direction.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_master_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    // Levels for active-low (trailing underscore) and active-high strobes
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Enable   = 1'b1;
    localparam logic Disable  = 1'b0;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bus_master_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_timer
//  Description : Loadable up-counter that flags expiry after TIMEOUT counted
//                cycles; used to bound the wait for slave ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Count value seen during the TIMEOUT-th enabled cycle after a load
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_port
//  Description : Requester endpoint of the two-master shared bus. Accepts one
//                core command, arbitrates via breq_/bgrt_, runs the bus cycle
//                and acknowledges. Optional XFER timeout: BUSMASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              breq_,
    input  logic              bgrt_,
    output logic              done,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rdy_
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_rw_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_busy_nxt;
    logic                w_ack_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_err_nxt;
    logic                w_breq_nxt;
    logic                w_done_nxt;
    logic                w_as_nxt;
    logic                w_bus_rw_nxt;
    logic [ADDR_W-1:0]   w_bus_addr_nxt;
    logic [DATA_W-1:0]   w_bus_wdata_nxt;
    logic                w_expire;

`ifdef BUSMASTER_TIMEOUT_EN
    logic w_tmr_load;
    logic w_tmr_en;

    assign w_tmr_load = (r_state == REQ) && (bgrt_ == Enable_);
    assign w_tmr_en   = (r_state == XFER);

    bus_master_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset_   (reset_),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_expire         = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rw_nxt        = r_rw;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_busy_nxt      = busy;
        w_ack_nxt       = Disable;
        w_rdata_nxt     = rdata;
        w_err_nxt       = 1'b0;
        w_breq_nxt      = breq_;
        w_done_nxt      = Disable;
        w_as_nxt        = bus_as_;
        w_bus_rw_nxt    = bus_rw;
        w_bus_addr_nxt  = bus_addr;
        w_bus_wdata_nxt = bus_wdata;

        case (r_state)
            IDLE: begin
                if (req) begin
                    w_rw_nxt    = rw;
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_busy_nxt  = 1'b1;
                    w_breq_nxt  = Enable_;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bgrt_ == Enable_) begin
                    w_as_nxt        = Enable_;
                    w_bus_rw_nxt    = r_rw;
                    w_bus_addr_nxt  = r_addr;
                    w_bus_wdata_nxt = r_wdata;
                    w_state_nxt     = XFER;
                end
            end
            XFER: begin
                // A ready coinciding with expiry counts as a normal completion
                if ((bus_rdy_ == Enable_) || w_expire) begin
                    w_as_nxt        = Disable_;
                    w_breq_nxt      = Disable_;
                    w_done_nxt      = Enable;
                    w_ack_nxt       = Enable;
                    w_bus_rw_nxt    = 1'b0;
                    w_bus_addr_nxt  = '0;
                    w_bus_wdata_nxt = '0;
                    w_state_nxt     = REL;
                    if (bus_rdy_ == Enable_) begin
                        if (r_rw == READ) begin
                            w_rdata_nxt = bus_rdata;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            REL: begin
                w_busy_nxt      = 1'b0;
                w_bus_rw_nxt    = 1'b0;
                w_bus_addr_nxt  = '0;
                w_bus_wdata_nxt = '0;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            busy      <= 1'b0;
            ack       <= Disable;
            rdata     <= '0;
            err       <= 1'b0;
            breq_     <= Disable_;
            done      <= Disable;
            bus_as_   <= Disable_;
            bus_rw    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rw      <= w_rw_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            busy      <= w_busy_nxt;
            ack       <= w_ack_nxt;
            rdata     <= w_rdata_nxt;
            err       <= w_err_nxt;
            breq_     <= w_breq_nxt;
            done      <= w_done_nxt;
            bus_as_   <= w_as_nxt;
            bus_rw    <= w_bus_rw_nxt;
            bus_addr  <= w_bus_addr_nxt;
            bus_wdata <= w_bus_wdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_master_port
//  Description : Self-checking bench for bus_master_port with a behavioural
//                arbiter/slave and a transaction-level expectation model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        reset_;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        breq_;
    logic        bgrt_;
    logic        done;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rdy_;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m_rdata     = 32'h0;

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .breq_     (breq_),
        .bgrt_     (bgrt_),
        .done      (done),
        .bus_as_   (bus_as_),
        .bus_rw    (bus_rw),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy_  (bus_rdy_)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete command, entered and left at a negedge with the DUT idle.
    // gd = cycles the grant is withheld, ws = wait states before ready.
    task automatic txn(input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                       input int gd, input int ws, input logic [31:0] t_rdata, input bit hold_req);
        rw    = t_rw;
        addr  = t_addr;
        wdata = t_wdata;
        req   = 1'b1;
        @(negedge clk);
        check("accept_busy", busy, 1);
        check("accept_breq", breq_, 0);
        check("accept_as", bus_as_, 1);
        // Anything on the command inputs now must be ignored
        req   = hold_req;
        rw    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            check("wait_grant_breq", breq_, 0);
            check("wait_grant_as", bus_as_, 1);
        end
        bgrt_ = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= ws + 1; k++) begin
            check("xfer_as", bus_as_, 0);
            check("xfer_addr", bus_addr, t_addr);
            check("xfer_rw", bus_rw, t_rw);
            check("xfer_wdata", bus_wdata, t_wdata);
            check("xfer_done", done, 0);
            check("xfer_breq", breq_, 0);
            if (k > 1) bgrt_ = 1'($urandom);
            bus_rdata = (k == ws + 1) ? t_rdata : $urandom;
            bus_rdy_  = (k == ws + 1) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        if (t_rw == 1'b0) m_rdata = t_rdata;
        bus_rdy_ = 1'b1;
        bgrt_    = 1'b1;
        check("rel_ack", ack, 1);
        check("rel_done", done, 1);
        check("rel_busy", busy, 1);
        check("rel_as", bus_as_, 1);
        check("rel_breq", breq_, 1);
        check("rel_err", err, 0);
        check("rel_rdata", rdata, m_rdata);
        @(negedge clk);
        check("idle_ack", ack, 0);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_breq", breq_, 1);
        check("idle_bus_addr", bus_addr, 0);
        check("idle_rdata", rdata, m_rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_    = 1'b0;
        req       = 1'b0;
        rw        = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bgrt_     = 1'b1;
        bus_rdata = 32'h0;
        bus_rdy_  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_breq", breq_, 1);
        check("rst_as", bus_as_, 1);
        check("rst_done", done, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bus_rw", bus_rw, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        reset_ = 1'b1;
        @(negedge clk);

        // Spurious grant while idle
        bgrt_ = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_breq", breq_, 1);
        check("spur_as", bus_as_, 1);
        check("spur_busy", busy, 0);
        bgrt_ = 1'b1;

        txn(1'b0, 32'h100, $urandom, 0, 0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h200, 32'h12345678, 0, 3, $urandom, 1'b0);
        txn(1'b0, 32'h300, $urandom, 10, 1, $urandom, 1'b0);

        // Back-to-back with req held high throughout
        txn(1'b0, 32'h400, $urandom, 1, 2, $urandom, 1'b1);
        txn(1'b1, 32'h500, $urandom, 0, 0, $urandom, 1'b0);

        for (int n = 0; n < 20; n++) begin
            txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), $urandom, 1'($urandom));
        end
        req = 1'b0;

`ifdef BUSMASTER_TIMEOUT_EN
        // Slave never responds: exit on the 8th XFER cycle with err
        rw   = 1'b0;
        addr = 32'h600;
        req  = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        bgrt_ = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            check("to_xfer_as", bus_as_, 0);
            check("to_xfer_ack", ack, 0);
            @(negedge clk);
        end
        bgrt_ = 1'b1;
        check("to_ack", ack, 1);
        check("to_err", err, 1);
        check("to_done", done, 1);
        check("to_rdata", rdata, m_rdata);
        @(negedge clk);
        check("to_err_clr", err, 0);
        check("to_busy", busy, 0);
        txn(1'b0, 32'h700, $urandom, 0, 2, $urandom, 1'b0);
`endif

        // Asynchronous reset in the middle of XFER
        rw   = 1'b0;
        addr = 32'h800;
        req  = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        bgrt_ = 1'b0;
        @(negedge clk);
        check("mid_xfer_as", bus_as_, 0);
        @(posedge clk);
        #2 reset_ = 1'b0;
        #1;
        m_rdata = 32'h0;
        check("arst_breq", breq_, 1);
        check("arst_as", bus_as_, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rdata", rdata, m_rdata);
        @(negedge clk);
        check("arst_done_hold", done, 0);
        bgrt_  = 1'b1;
        reset_ = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h900, $urandom, 0, 0, $urandom, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Requester-side endpoint of the two-master shared-bus protocol: one instance per master (CPU fetch or data side), tied to one breq_/bgrt_ pair of the bus arbiter.
- Accepts a single read/write command from the core and raises breq_.
- Once the grant arrives, it drives the bus cycle and waits for the slave's ready.
- It then pulses done to release the arbiter, returns read data and acknowledges the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles waiting for bus_rdy_ (used only with the optional feature); counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_  in  1  asynchronous, active-low reset.
- req  in  1  core command valid (active-high), sampled only when busy=0.
- rw  in  1  1=write, 0=read.
- addr  in  ADDR_W  command address.
- wdata  in  DATA_W  write data.
- busy  out  1  command in progress.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid from the cycle ack=1 until the next read completes.
- err  out  1  completion was a timeout (tied 0 without the feature).
- breq_  out  1  bus request to arbiter, active-low.
- bgrt_  in  1  bus grant from arbiter, active-low.
- done  out  1  one-cycle release pulse to arbiter, active-high; wired-OR with the other master externally.
- bus_as_  out  1  address strobe, active-low.
- bus_rw  out  1  bus direction.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  slave read data.
- bus_rdy_  in  1  slave ready, active-low.

Behaviour:
- All outputs are registered.
- Reset state: IDLE. Outputs: breq_=1, bus_as_=1, done=0, ack=0, busy=0, err=0, rdata=0, bus_rw=0, bus_addr=0, bus_wdata=0. Command latches are cleared to 0.
- States: IDLE, REQ, XFER, REL.
- IDLE:
  - On req=1, latch rw/addr/wdata, set busy=1 and breq_=0, go to REQ.
  - req is ignored whenever busy=1; the core must hold the command only for the accepting cycle.
- REQ:
  - Hold breq_=0 until bgrt_=0 is sampled.
  - In that cycle, drive bus_addr/bus_rw/bus_wdata from the latches and set bus_as_=0, then go to XFER.
  - Minimum latency from req to bus_as_ low is 3 edges, because the arbiter registers its grant.
- XFER:
  - Hold bus_as_=0 and the bus signals stable until bus_rdy_=0 is sampled.
  - In that cycle:
    - capture bus_rdata into rdata (reads only; writes leave rdata unchanged);
    - set bus_as_=1, breq_=1, done=1, ack=1;
    - go to REL.
- REL (one cycle):
  - Clear done and ack.
  - Return bus_addr/bus_wdata/bus_rw to 0 and clear busy, then go to IDLE.
  - breq_ is already high, so the arbiter returns to Free and does not re-grant this master.
  - Back-to-back commands cost one idle cycle.
- Bus outputs are driven to 0 and bus_as_=1 whenever the state is not XFER; there is no tristate.
- If bgrt_ goes low while in IDLE or REL (a spurious grant), it is ignored and breq_ stays as specified.
- If bgrt_ deasserts during XFER (the arbiter was reset), the cycle continues; done still pulses.
- Asynchronous reset in any state returns to IDLE immediately, releasing breq_ and bus_as_. No done is issued; the arbiter is reset by the same reset_.

Optional Feature:
- Macro: BUSMASTER_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on entry to XFER and increments each cycle in XFER.
  - When it reaches TIMEOUT with bus_rdy_ still 1, take the XFER exit path (bus_as_=1, breq_=1, done=1, ack=1, go to REL) with err=1.
  - rdata is not updated.
  - err clears in REL.
- Without the macro: no counter exists, err is constant 0, and XFER waits indefinitely.

Decomposition:
- Shared package/define.h:
  - state encodings IDLE/REQ/XFER/REL;
  - existing Enable_/Disable_ and Enable/Disable constants;
  - a READ/WRITE encoding for rw.
- Natural sub-module: bus_master_timer (loadable down/up counter with expire flag), instantiated only under BUSMASTER_TIMEOUT_EN.

Test Plan:
- Read, immediate grant:
  - Stimulus: req=1, rw=0, addr=0x100; bgrt_ low one cycle after breq_; bus_rdy_ low on first XFER cycle with bus_rdata=0xDEADBEEF.
  - Response: bus_as_ low with bus_addr=0x100; rdata=0xDEADBEEF with ack=1 and done=1 in the same single cycle; busy low the following cycle.
- Write, 3 wait states:
  - Stimulus: rw=1, addr=0x200, wdata=0x12345678; bus_rdy_ low only on the 4th XFER cycle.
  - Response: bus_wdata=0x12345678 stable all 4 cycles; one done pulse; rdata unchanged.
- Delayed grant:
  - Stimulus: bgrt_ held high 10 cycles.
  - Response: breq_ stays 0, bus_as_ stays 1 throughout; transfer proceeds normally after grant.
- Back-to-back and busy handling:
  - Stimulus: two commands, with req held high continuously.
  - Response: second breq_ falls exactly 2 cycles after first done; req ignored while busy.
- Reset mid-XFER:
  - Stimulus: reset_ low asynchronously mid-clock during XFER.
  - Response: breq_=1, bus_as_=1, busy=0 before the next edge; no done.
- Timeout (with BUSMASTER_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: bus_rdy_ never asserted.
  - Response: ack=1, err=1, done=1 on the 8th XFER cycle; a subsequent normal read returns err=0.
